// File: rtl/cm3_matrix_wrr_arbiter_if.sv
// Signal bundle between the cm3 matrix output stage and its weighted round-robin arbiter.
// The master side drives the requests and the observed output transfer; the slave side returns the mux select.
interface cm3_matrix_wrr_arbiter_if;
   logic [3:0] req_port;
   logic       HREADYM;
   logic       HSELM;
   logic [1:0] HTRANSM;
   logic [2:0] HBURSTM;
   logic       HMASTLOCKM;
   logic [1:0] addr_in_port;
   logic       no_port;
   logic [3:0] starving;

   modport master (
      output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
      input  addr_in_port, no_port, starving
   );

   modport slave (
      input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
      output addr_in_port, no_port, starving
   );
endinterface

// File: rtl/cm3_matrix_wrr_arbiter.sv
// Weighted round-robin arbiter for one shared AHB slave port of the cm3 bus matrix.
// It honours burst boundaries and locks, and adds per-port starvation escalation.
module cm3_matrix_wrr_arbiter #(
   parameter int WEIGHT0      = 4,
   parameter int WEIGHT1      = 4,
   parameter int WEIGHT2      = 2,
   parameter int WEIGHT3      = 1,
   parameter int STARVE_LIMIT = 32
) (
   input logic HCLK,
   input logic HRESET,
   cm3_matrix_wrr_arbiter_if.slave bus
);

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_BUSY   = 2'b01;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] TRANS_SEQ    = 2'b11;
   localparam logic [7:0] LIMIT        = 8'(STARVE_LIMIT);

   function automatic logic [3:0] weight_of(input logic [1:0] port);
      case (port)
         2'd0:    weight_of = 4'(WEIGHT0);
         2'd1:    weight_of = 4'(WEIGHT1);
         2'd2:    weight_of = 4'(WEIGHT2);
         default: weight_of = 4'(WEIGHT3);
      endcase
   endfunction

   logic [1:0] owner_q, owner_d;
   logic       none_q, none_d;
   logic [3:0] credit_q, credit_d, credit_left;
   logic [3:0] remain_q, remain_d;
   logic [7:0] wait_q [4];
   logic [7:0] wait_d [4];
   logic [3:0] starving_q, starving_d;
   logic       hold, nonseq_acc, fresh;
   logic [3:0] starve_hit;
   logic [1:0] starve_pick, rr_start, rr_pick, rr_idx;

   always_comb begin
      remain_d = remain_q;
      if (!bus.HSELM || bus.HTRANSM == TRANS_IDLE) begin
         remain_d = 4'd0;
      end else begin
         case (bus.HTRANSM)
            TRANS_NONSEQ: begin
               case (bus.HBURSTM)
                  3'b010, 3'b011: remain_d = 4'd3;
                  3'b100, 3'b101: remain_d = 4'd7;
                  3'b110, 3'b111: remain_d = 4'd15;
                  default:        remain_d = 4'd0;
               endcase
            end
            TRANS_SEQ:  remain_d = (remain_q != 4'd0) ? remain_q - 4'd1 : 4'd0;
            TRANS_BUSY: remain_d = remain_q;
            default:    remain_d = 4'd0;
         endcase
      end
   end

   assign hold       = (remain_d != 4'd0);
   assign nonseq_acc = bus.HSELM && (bus.HTRANSM == TRANS_NONSEQ);
   // The owner keeps the port only while credit remains after the transfer now being counted.
   assign credit_left = (nonseq_acc && credit_q != 4'd0) ? credit_q - 4'd1 : credit_q;
   assign starve_hit  = starving_q & bus.req_port;
   assign rr_start    = none_q ? 2'd0 : owner_q + 2'd1;

   always_comb begin
      starve_pick = 2'd0;
      rr_pick     = 2'd0;
      rr_idx      = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (starve_hit[i]) starve_pick = 2'(i);
      end
      for (int k = 3; k >= 0; k--) begin
         rr_idx = rr_start + 2'(k);
         if (bus.req_port[rr_idx]) rr_pick = rr_idx;
      end
   end

   always_comb begin
      owner_d = owner_q;
      none_d  = none_q;
      fresh   = 1'b0;
      if (bus.HMASTLOCKM || hold) begin
         owner_d = owner_q;
      end else if (|starve_hit) begin
         owner_d = starve_pick;
         none_d  = 1'b0;
         fresh   = 1'b1;
      end else if (!none_q && bus.req_port[owner_q] && credit_left != 4'd0) begin
         owner_d = owner_q;
      end else if (|bus.req_port) begin
         owner_d = rr_pick;
         none_d  = 1'b0;
         fresh   = 1'b1;
      end else if (!(bus.HSELM && !none_q)) begin
         none_d  = 1'b1;
      end
   end

   always_comb begin
      credit_d = credit_q;
      if (fresh) begin
         credit_d = weight_of(owner_d);
      end else if (!none_q && nonseq_acc) begin
         credit_d = credit_left;
      end
   end

   always_comb begin
      for (int n = 0; n < 4; n++) begin
         wait_d[n] = wait_q[n];
         if (!bus.req_port[n] || (!none_d && owner_d == 2'(n))) begin
            wait_d[n] = 8'd0;
         end else if ((none_q || owner_q != 2'(n)) && wait_q[n] < LIMIT) begin
            wait_d[n] = wait_q[n] + 8'd1;
         end
         starving_d[n] = (wait_d[n] == LIMIT);
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         owner_q    <= 2'd0;
         none_q     <= 1'b1;
         credit_q   <= 4'd0;
         remain_q   <= 4'd0;
         starving_q <= 4'd0;
         for (int n = 0; n < 4; n++) wait_q[n] <= 8'd0;
      end else if (bus.HREADYM) begin
         owner_q    <= owner_d;
         none_q     <= none_d;
         credit_q   <= credit_d;
         remain_q   <= remain_d;
         starving_q <= starving_d;
         for (int n = 0; n < 4; n++) wait_q[n] <= wait_d[n];
      end
   end

   assign bus.addr_in_port = owner_q;
   assign bus.no_port      = none_q;
   assign bus.starving     = starving_q;

endmodule

// File: tb/tb_cm3_matrix_wrr_arbiter.sv
// Randomised and directed bench for cm3_matrix_wrr_arbiter against a transaction-level ownership model.
module tb_cm3_matrix_wrr_arbiter;

   localparam int LIMIT = 8;

   logic HCLK = 1'b0;
   logic HRESET;
   int   vectors = 0;
   int   miscompares = 0;

   int   m_owner, m_credit, m_remain;
   bit   m_none;
   int   m_wait [4];
   int   lock_left;

   cm3_matrix_wrr_arbiter_if bus ();

   cm3_matrix_wrr_arbiter #(
      .WEIGHT0(4), .WEIGHT1(4), .WEIGHT2(2), .WEIGHT3(1), .STARVE_LIMIT(LIMIT)
   ) dut (
      .HCLK  (HCLK),
      .HRESET(HRESET),
      .bus   (bus)
   );

   always #5 HCLK = ~HCLK;

   function automatic int weight(input int p);
      int tbl [4];
      tbl = '{4, 4, 2, 1};
      return tbl[p];
   endfunction

   function automatic int beats(input logic [2:0] b);
      case (b)
         3'd2, 3'd3: return 4;
         3'd4, 3'd5: return 8;
         3'd6, 3'd7: return 16;
         default:    return 1;
      endcase
   endfunction

   function automatic logic [3:0] model_starving();
      logic [3:0] s;
      for (int n = 0; n < 4; n++) s[n] = (m_wait[n] == LIMIT);
      return s;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
      end
   endtask

   // One accepted HCLK edge as seen by a port owner: who transfers next, how much of its tenure is left.
   task automatic modelStep();
      int  left, new_owner, starver;
      bit  new_none, keep_burst, nonseq, fresh;
      if (HRESET) begin
         m_owner = 0; m_none = 1; m_credit = 0; m_remain = 0;
         for (int n = 0; n < 4; n++) m_wait[n] = 0;
         return;
      end
      if (!bus.HREADYM) return;
      if (!bus.HSELM || bus.HTRANSM == 2'd0) left = 0;
      else if (bus.HTRANSM == 2'd2)          left = beats(bus.HBURSTM) - 1;
      else if (bus.HTRANSM == 2'd3)          left = (m_remain > 0) ? m_remain - 1 : 0;
      else                                   left = m_remain;
      keep_burst = (left > 0);
      nonseq = bus.HSELM && bus.HTRANSM == 2'd2;
      starver = -1;
      for (int n = 3; n >= 0; n--) if (m_wait[n] == LIMIT && bus.req_port[n]) starver = n;
      new_owner = m_owner; new_none = m_none; fresh = 0;
      if (bus.HMASTLOCKM || keep_burst) begin
      end else if (starver >= 0) begin
         new_owner = starver; new_none = 0; fresh = 1;
      end else if (!m_none && bus.req_port[m_owner] && (m_credit - ((nonseq && m_credit > 0) ? 1 : 0)) > 0) begin
      end else if (bus.req_port != 4'd0) begin
         for (int k = 4; k >= 1; k--)
            if (bus.req_port[(m_none ? k - 1 : m_owner + k) % 4]) new_owner = (m_none ? k - 1 : m_owner + k) % 4;
         new_none = 0; fresh = 1;
      end else if (!(bus.HSELM && !m_none)) begin
         new_none = 1;
      end
      for (int n = 0; n < 4; n++) begin
         if (!bus.req_port[n] || (!new_none && new_owner == n)) m_wait[n] = 0;
         else if ((m_none || m_owner != n) && m_wait[n] < LIMIT) m_wait[n]++;
      end
      if (fresh) m_credit = weight(new_owner);
      else if (!m_none && nonseq && m_credit > 0) m_credit--;
      m_owner = new_owner; m_none = new_none; m_remain = left;
   endtask

   task automatic applyStimulus(input bit rst, input logic [3:0] req, input bit ready, input bit sel,
                                input logic [1:0] trans, input logic [2:0] burst, input bit lock);
      HRESET = rst;
      bus.req_port = req; bus.HREADYM = ready; bus.HSELM = sel;
      bus.HTRANSM = trans; bus.HBURSTM = burst; bus.HMASTLOCKM = lock;
      @(posedge HCLK);
      modelStep();
      #1;
      checkOutput("addr_in_port", 32'(bus.addr_in_port), 32'(m_owner));
      checkOutput("no_port", 32'(bus.no_port), 32'(m_none));
      checkOutput("starving", 32'(bus.starving), 32'(model_starving()));
   endtask

   initial begin
      HRESET = 1'b1;
      bus.req_port = 4'd0; bus.HREADYM = 1'b0; bus.HSELM = 1'b0;
      bus.HTRANSM = 2'd0; bus.HBURSTM = 3'd0; bus.HMASTLOCKM = 1'b0;
      m_owner = 0; m_none = 1; m_credit = 0; m_remain = 0;
      for (int n = 0; n < 4; n++) m_wait[n] = 0;

      // Reset with HREADYM low still clears, then a lone request is granted on the next edge.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, 4'b0000, 0, 0, 2'd0, 3'd0, 0);
         checkOutput("reset_no_port", 32'(bus.no_port), 32'd1);
         checkOutput("reset_addr", 32'(bus.addr_in_port), 32'd0);
         checkOutput("reset_starving", 32'(bus.starving), 32'd0);
      end
      applyStimulus(0, 4'b0100, 1, 0, 2'd0, 3'd0, 0);
      checkOutput("first_grant_addr", 32'(bus.addr_in_port), 32'd2);
      checkOutput("first_grant_no_port", 32'(bus.no_port), 32'd0);

      // Weight 4 against weight 1 with SINGLE NONSEQs every cycle gives a period-5 pattern.
      applyStimulus(1, 4'b0000, 1, 0, 2'd0, 3'd0, 0);
      for (int k = 1; k <= 20; k++) begin
         applyStimulus(0, 4'b1001, 1, 1, 2'd2, 3'd0, 0);
         checkOutput("wrr_pattern", 32'(bus.addr_in_port), ((k - 1) % 5 == 4) ? 32'd3 : 32'd0);
      end

      // Port 1 with one credit left runs an INCR8 with two BUSY beats; port 2 waits for its end.
      applyStimulus(1, 4'b0000, 1, 0, 2'd0, 3'd0, 0);
      applyStimulus(0, 4'b0010, 1, 0, 2'd0, 3'd0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 4'b0010, 1, 1, 2'd2, 3'd0, 0);
      applyStimulus(0, 4'b0110, 1, 1, 2'd2, 3'd5, 0);
      checkOutput("burst_start", 32'(bus.addr_in_port), 32'd1);
      begin
         logic [1:0] beat_seq [9];
         beat_seq = '{2'd3, 2'd3, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
         for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 4'b0110, 1, 1, beat_seq[i], 3'd5, 0);
            checkOutput("burst_hold", 32'(bus.addr_in_port), (i == 8) ? 32'd2 : 32'd1);
         end
      end

      // A lock keeps port 0 while port 3 starves; port 3 wins as soon as the lock drops.
      applyStimulus(1, 4'b0000, 1, 0, 2'd0, 3'd0, 0);
      applyStimulus(0, 4'b0001, 1, 0, 2'd0, 3'd0, 0);
      for (int i = 0; i < 12; i++) applyStimulus(0, 4'b1001, 1, 1, 2'd2, 3'd0, 1);
      checkOutput("lock_owner", 32'(bus.addr_in_port), 32'd0);
      checkOutput("lock_starving", 32'(bus.starving), 32'b1000);
      applyStimulus(0, 4'b1001, 1, 0, 2'd0, 3'd0, 0);
      checkOutput("unlock_grant", 32'(bus.addr_in_port), 32'd3);

      // A long HREADYM stall freezes everything regardless of request churn.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 4'($urandom_range(0, 15)), 0, 1, 2'd2, 3'd7, 0);
         checkOutput("stall_addr", 32'(bus.addr_in_port), 32'd3);
         checkOutput("stall_no_port", 32'(bus.no_port), 32'd0);
      end

      // Reset in the middle of an INCR16 drops the tenure on that edge.
      applyStimulus(1, 4'b0000, 1, 0, 2'd0, 3'd0, 0);
      applyStimulus(0, 4'b0001, 1, 0, 2'd0, 3'd0, 0);
      applyStimulus(0, 4'b0001, 1, 1, 2'd2, 3'd7, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 4'b0011, 1, 1, 2'd3, 3'd7, 0);
      applyStimulus(1, 4'b0011, 0, 1, 2'd3, 3'd7, 0);
      checkOutput("midburst_reset", 32'(bus.no_port), 32'd1);

      lock_left = 0;
      for (int i = 0; i < 3000; i++) begin
         bit lock;
         if (lock_left == 0 && $urandom_range(0, 40) == 0) lock_left = $urandom_range(1, 20);
         lock = (lock_left > 0);
         if (lock_left > 0) lock_left--;
         applyStimulus($urandom_range(0, 399) == 0, 4'($urandom_range(0, 15)),
                       $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 80,
                       2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), lock);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
